agc_ctrl: RTL
=============

Name: agc_ctrl

Overview:
- Acquisition/tracking sequencer for the AGC loop: drives agc_en, pwr_est_prd and pwm_step of the power-estimator / PWM-generator pair.
- Uses the per-estimate completion pulse and the in-range flag (agc_fix) to move coarse -> fine -> locked, with lock-loss fallback and a bounded acquisition time.
- Sits between the register bank and the AGC datapath; all outputs are registered.

Parameters:
- COARSE_PRD, 2'd0, pwr_est_prd during COARSE (short window).
- FINE_PRD, 2'd2, pwr_est_prd during FINE and LOCKED.
- COARSE_STEP, 2'd3, pwm_step in COARSE.
- FINE_STEP, 2'd1, pwm_step in FINE.
- TRACK_STEP, 2'd0, pwm_step in LOCKED.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- agc_start  in  1  one-cycle start pulse; honoured only in IDLE or FAIL
- agc_stop  in  1  one-cycle stop pulse; honoured in any state
- pwr_est_end  in  1  one-cycle pulse per completed estimate
- agc_fix  in  1  in-range flag; sampled only when pwr_est_end=1
- coarse_cnt_th  in  4  consecutive hits to leave COARSE
- lock_cnt_th  in  4  consecutive hits in FINE to declare lock
- unlock_cnt_th  in  4  consecutive misses to fall back one level
- timeout_th  in  16  max counted estimates in COARSE+FINE before FAIL
- agc_en  out  1  estimator enable
- pwr_est_prd  out  2  estimation period select
- pwm_step  out  2  loop step select
- agc_locked  out  1  high while in LOCKED
- agc_timeout  out  1  high while in FAIL
- agc_state  out  3  IDLE=0, COARSE=1, FINE=2, LOCKED=3, FAIL=4

Behaviour:
- Reset: state IDLE; agc_en=0, pwr_est_prd=FINE_PRD, pwm_step=FINE_STEP, agc_locked=0, agc_timeout=0, agc_state=0. All counters=0, skip flag=1.
- Outputs are registered from next-state: visible one cycle after the triggering input.
- Counted estimate: pwr_est_end=1 and skip flag=0. On every state entry the skip flag is set. The first pwr_est_end after entry only clears the flag and is otherwise ignored, because that window straddles a period change.
- hit_cnt/miss_cnt (4 b):
  - Counted agc_fix=1: hit_cnt+1 (saturating at 15), miss_cnt=0.
  - Counted agc_fix=0: miss_cnt+1 (saturating at 15), hit_cnt=0.
  - Both are cleared on every state entry.
- Thresholds: value 0 behaves as 1. Comparison is hit_cnt_next >= th.
- IDLE: agc_en=0. agc_start -> COARSE; tmo_cnt cleared.
- COARSE: agc_en=1, COARSE_PRD, COARSE_STEP.
  - hit threshold (coarse_cnt_th) -> FINE.
  - Misses cause no fallback.
- FINE: FINE_PRD, FINE_STEP.
  - hit threshold (lock_cnt_th) -> LOCKED.
  - miss threshold (unlock_cnt_th) -> COARSE.
- LOCKED: FINE_PRD, TRACK_STEP, agc_locked=1.
  - miss threshold (unlock_cnt_th) -> FINE.
  - tmo_cnt frozen.
- tmo_cnt (16 b):
  - Increments on each counted estimate in COARSE or FINE, saturating.
  - Cleared on agc_start, and on entering LOCKED.
  - Not cleared on LOCKED->FINE or FINE->COARSE.
  - Reaching timeout_th (0 means timeout disabled) -> FAIL, with priority over hit/miss transitions in the same cycle.
- FAIL: agc_en=0, agc_timeout=1, prd/step hold their last values. agc_start -> COARSE (restart); agc_stop -> IDLE.
- agc_stop: -> IDLE from any state. Wins over agc_start, pwr_est_end and timeout in the same cycle.
- agc_start outside IDLE/FAIL: ignored.
- Threshold inputs are sampled live and may change at any time; a lowered threshold applies at the next counted estimate.
- Async reset mid-operation: immediate return to the reset values, no partial state retained.

Test Plan:
- Reset, pulse agc_start, 3 estimates fix=1, coarse_cnt_th=2, lock_cnt_th=3 -> first ignored (skip); agc_state=2 one cycle after 3rd pulse; pwm_step=1, pwr_est_prd=2.
- From FINE, 4 counted fix=1 (1 skipped + 3) -> LOCKED, agc_locked=1, pwm_step=0. Then unlock_cnt_th=2 with fix 0,1,0,0 -> FINE only after the last two consecutive misses.
- timeout_th=5, agc_fix held 0 in COARSE -> after skip + 5 counted estimates agc_state=4, agc_en=0, agc_timeout=1. agc_start -> COARSE, tmo_cnt restarts.
- agc_stop coincident with pwr_est_end that would hit lock threshold -> IDLE, agc_locked stays 0. agc_start while LOCKED -> no change.
- Thresholds =0 -> each single counted hit advances one state. timeout_th=0 with 100 misses -> never FAIL.
- Assert reset while LOCKED -> all outputs at reset values in the same cycle (asynchronous). Release, pwr_est_end pulses with no agc_start -> remains IDLE.

Source files
------------

// File: rtl/agc_ctrl.sv
// agc_ctrl: acquisition/tracking sequencer for the AGC loop.
// Moves COARSE -> FINE -> LOCKED on runs of in-range estimates and falls back
// one level on runs of out-of-range estimates. COARSE+FINE time is bounded by
// an estimate-count timeout that parks the loop in FAIL. Every output comes
// from a flop loaded with the value that belongs to the next state.
module agc_ctrl #(
    parameter logic [1:0] COARSE_PRD  = 2'd0,
    parameter logic [1:0] FINE_PRD    = 2'd2,
    parameter logic [1:0] COARSE_STEP = 2'd3,
    parameter logic [1:0] FINE_STEP   = 2'd1,
    parameter logic [1:0] TRACK_STEP  = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        agc_start,
    input  logic        agc_stop,
    input  logic        pwr_est_end,
    input  logic        agc_fix,
    input  logic [3:0]  coarse_cnt_th,
    input  logic [3:0]  lock_cnt_th,
    input  logic [3:0]  unlock_cnt_th,
    input  logic [15:0] timeout_th,
    output logic        agc_en,
    output logic [1:0]  pwr_est_prd,
    output logic [1:0]  pwm_step,
    output logic        agc_locked,
    output logic        agc_timeout,
    output logic [2:0]  agc_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COARSE = 3'd1,
        ST_FINE   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hit_cnt_q, hit_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        skip_q, skip_d;

    logic        agc_en_q, agc_en_d;
    logic [1:0]  pwr_est_prd_q, pwr_est_prd_d;
    logic [1:0]  pwm_step_q, pwm_step_d;
    logic        agc_locked_q, agc_locked_d;
    logic        agc_timeout_q, agc_timeout_d;
    logic [2:0]  agc_state_q, agc_state_d;

    // Working values for the estimate being evaluated this cycle
    logic        tracking;
    logic        counted;
    logic [3:0]  hit_upd;
    logic [3:0]  miss_upd;
    logic [15:0] tmo_upd;
    logic [3:0]  coarse_th_eff;
    logic [3:0]  lock_th_eff;
    logic [3:0]  unlock_th_eff;
    logic        tmo_reached;
    logic        hit_coarse;
    logic        hit_lock;
    logic        miss_unlock;

    // Estimate qualification, saturating counter updates and threshold tests
    always_comb begin
        tracking = (state_q == ST_COARSE) || (state_q == ST_FINE) ||
                   (state_q == ST_LOCKED);
        // The first estimate after a state change straddles a period change,
        // so it only clears the skip flag and is not evaluated.
        counted  = tracking && pwr_est_end && !skip_q;

        if (agc_fix) begin
            hit_upd  = (hit_cnt_q == 4'hF) ? hit_cnt_q : hit_cnt_q + 4'd1;
            miss_upd = 4'd0;
        end else begin
            hit_upd  = 4'd0;
            miss_upd = (miss_cnt_q == 4'hF) ? miss_cnt_q : miss_cnt_q + 4'd1;
        end
        tmo_upd = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;

        // A zero threshold would be met without any hit; treat it as one.
        coarse_th_eff = (coarse_cnt_th == 4'd0) ? 4'd1 : coarse_cnt_th;
        lock_th_eff   = (lock_cnt_th   == 4'd0) ? 4'd1 : lock_cnt_th;
        unlock_th_eff = (unlock_cnt_th == 4'd0) ? 4'd1 : unlock_cnt_th;

        // timeout_th of zero disables the acquisition time limit
        tmo_reached = (timeout_th != 16'd0) && (tmo_upd >= timeout_th);
        hit_coarse  = hit_upd  >= coarse_th_eff;
        hit_lock    = hit_upd  >= lock_th_eff;
        miss_unlock = miss_upd >= unlock_th_eff;
    end

    // Next-state, counter and next-output computation
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        skip_d     = skip_q;

        if (tracking && pwr_est_end) begin
            skip_d = 1'b0;
        end
        if (counted) begin
            hit_cnt_d  = hit_upd;
            miss_cnt_d = miss_upd;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (agc_start) begin
                    state_d   = ST_COARSE;
                    tmo_cnt_d = 16'd0;
                end
            end
            ST_COARSE: begin
                // Misses in COARSE only consume acquisition time
                if (counted) begin
                    tmo_cnt_d = tmo_upd;
                    if (tmo_reached) begin
                        state_d = ST_FAIL;
                    end else if (hit_coarse) begin
                        state_d = ST_FINE;
                    end
                end
            end
            ST_FINE: begin
                if (counted) begin
                    tmo_cnt_d = tmo_upd;
                    if (tmo_reached) begin
                        state_d = ST_FAIL;
                    end else if (hit_lock) begin
                        state_d   = ST_LOCKED;
                        tmo_cnt_d = 16'd0;
                    end else if (miss_unlock) begin
                        state_d = ST_COARSE;
                    end
                end
            end
            ST_LOCKED: begin
                // Acquisition timer is frozen while locked
                if (counted && miss_unlock) begin
                    state_d = ST_FINE;
                end
            end
            ST_FAIL: begin
                if (agc_start) begin
                    state_d   = ST_COARSE;
                    tmo_cnt_d = 16'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stop overrides start, estimates and timeout in the same cycle
        if (agc_stop) begin
            state_d   = ST_IDLE;
            tmo_cnt_d = tmo_cnt_q;
        end

        // Every state change restarts hit/miss runs and re-arms the skip
        if (state_d != state_q) begin
            hit_cnt_d  = 4'd0;
            miss_cnt_d = 4'd0;
            skip_d     = 1'b1;
        end

        agc_en_d      = 1'b0;
        pwr_est_prd_d = FINE_PRD;
        pwm_step_d    = FINE_STEP;
        agc_locked_d  = 1'b0;
        agc_timeout_d = 1'b0;
        agc_state_d   = state_d;

        unique case (state_d)
            ST_IDLE: begin
                agc_en_d = 1'b0;
            end
            ST_COARSE: begin
                agc_en_d      = 1'b1;
                pwr_est_prd_d = COARSE_PRD;
                pwm_step_d    = COARSE_STEP;
            end
            ST_FINE: begin
                agc_en_d      = 1'b1;
                pwr_est_prd_d = FINE_PRD;
                pwm_step_d    = FINE_STEP;
            end
            ST_LOCKED: begin
                agc_en_d      = 1'b1;
                pwr_est_prd_d = FINE_PRD;
                pwm_step_d    = TRACK_STEP;
                agc_locked_d  = 1'b1;
            end
            ST_FAIL: begin
                // Loop settings stay where acquisition gave up
                agc_en_d      = 1'b0;
                pwr_est_prd_d = pwr_est_prd_q;
                pwm_step_d    = pwm_step_q;
                agc_timeout_d = 1'b1;
            end
            default: begin
                agc_en_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hit_cnt_q     <= 4'd0;
            miss_cnt_q    <= 4'd0;
            tmo_cnt_q     <= 16'd0;
            skip_q        <= 1'b1;
            agc_en_q      <= 1'b0;
            pwr_est_prd_q <= FINE_PRD;
            pwm_step_q    <= FINE_STEP;
            agc_locked_q  <= 1'b0;
            agc_timeout_q <= 1'b0;
            agc_state_q   <= 3'd0;
        end else begin
            state_q       <= state_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            skip_q        <= skip_d;
            agc_en_q      <= agc_en_d;
            pwr_est_prd_q <= pwr_est_prd_d;
            pwm_step_q    <= pwm_step_d;
            agc_locked_q  <= agc_locked_d;
            agc_timeout_q <= agc_timeout_d;
            agc_state_q   <= agc_state_d;
        end
    end

    assign agc_en      = agc_en_q;
    assign pwr_est_prd = pwr_est_prd_q;
    assign pwm_step    = pwm_step_q;
    assign agc_locked  = agc_locked_q;
    assign agc_timeout = agc_timeout_q;
    assign agc_state   = agc_state_q;

endmodule
